sseg4_decode: RTL and testbench

SSEG4_DECODE -- requirements
Module: sseg4_decode

---
 rtl/sseg4_decode.sv | 167 ++++++++++++++++
 tb/tb_sseg4_decode.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sseg4_decode.sv
// sseg4_decode: recovers a 4-digit hex value from a multiplexed, active-low
// seven-segment display bus. Each digit is sampled once the anodes have been
// stable long enough. A frame is published once all four digits have been seen.
module sseg4_decode #(
    parameter int SETTLE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg,
    input  logic [3:0]  an,
    input  logic        dp,
    output logic [15:0] data,
    output logic [3:0]  dp_mask,
    output logic        valid,
    output logic        err
);

    typedef enum logic {
        SCAN,
        HOLD
    } state_t;

    localparam logic [7:0] SETTLE_M1 = 8'(SETTLE - 1);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  an_q;
    logic [7:0]  stable_cnt;
    logic [15:0] shadow;
    logic [15:0] shadow_nxt;
    logic [3:0]  shadow_dp;
    logic [3:0]  shadow_dp_nxt;
    logic [3:0]  seen;
    logic [3:0]  seen_nxt;

    logic        an_changed;
    logic        an_blank;
    logic        sample_pt;
    logic        digit_hit;
    logic [1:0]  digit_idx;
    logic        multi_low;
    logic [6:0]  seg_hi;
    logic        seg_ok;
    logic [3:0]  nibble;
    logic        good_sample;
    logic        bad_sample;
    logic        frame_done;

    assign an_changed = (an != an_q);
    assign an_blank   = (an == 4'b1111);
    assign seg_hi     = ~seg;
    assign sample_pt  = (state == SCAN) && !an_changed && (stable_cnt == SETTLE_M1);
    assign multi_low  = !an_blank && !digit_hit;

    // Identify which digit is driven; only exactly one low anode is a real digit
    always_comb begin
        digit_hit = 1'b1;
        digit_idx = 2'd0;
        case (an)
            4'b1110: digit_idx = 2'd0;
            4'b1101: digit_idx = 2'd1;
            4'b1011: digit_idx = 2'd2;
            4'b0111: digit_idx = 2'd3;
            default: digit_hit = 1'b0;
        endcase
    end

    // Translate the active-high segment pattern back into its hex value
    always_comb begin
        seg_ok = 1'b1;
        nibble = 4'h0;
        case (seg_hi)
            7'h3F: nibble = 4'h0;
            7'h06: nibble = 4'h1;
            7'h5B: nibble = 4'h2;
            7'h4F: nibble = 4'h3;
            7'h66: nibble = 4'h4;
            7'h6D: nibble = 4'h5;
            7'h7D: nibble = 4'h6;
            7'h07: nibble = 4'h7;
            7'h7F: nibble = 4'h8;
            7'h6F: nibble = 4'h9;
            7'h77: nibble = 4'hA;
            7'h7C: nibble = 4'hB;
            7'h39: nibble = 4'hC;
            7'h5E: nibble = 4'hD;
            7'h79: nibble = 4'hE;
            7'h71: nibble = 4'hF;
            default: seg_ok = 1'b0;
        endcase
    end

    assign good_sample = sample_pt && digit_hit && seg_ok;
    assign bad_sample  = sample_pt && (multi_low || (digit_hit && !seg_ok));

    // Merge a good sample into the shadow copy; a frame completes when every digit is seen
    always_comb begin
        shadow_nxt    = shadow;
        shadow_dp_nxt = shadow_dp;
        seen_nxt      = seen;
        if (good_sample) begin
            shadow_nxt[{digit_idx, 2'b00} +: 4] = nibble;
            shadow_dp_nxt[digit_idx]            = ~dp;
            seen_nxt[digit_idx]                 = 1'b1;
        end
    end

    assign frame_done = good_sample && (seen_nxt == 4'b1111);

    // Next-state: leave SCAN after any sample point on a non-blank digit, return on anode change
    always_comb begin
        state_nxt = state;
        case (state)
            SCAN:    if (sample_pt && !an_blank) state_nxt = HOLD;
            HOLD:    if (an_changed) state_nxt = SCAN;
            default: state_nxt = SCAN;
        endcase
    end

    // Anode history and saturating stability counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_q       <= 4'b1111;
            stable_cnt <= 8'd0;
        end else begin
            an_q <= an;
            if (an_changed) begin
                stable_cnt <= 8'd0;
            end else if (stable_cnt != 8'hFF) begin
                stable_cnt <= stable_cnt + 8'd1;
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SCAN;
        end else begin
            state <= state_nxt;
        end
    end

    // Shadow capture, frame publication and one-cycle status pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow    <= 16'h0000;
            shadow_dp <= 4'b0000;
            seen      <= 4'b0000;
            data      <= 16'h0000;
            dp_mask   <= 4'b0000;
            valid     <= 1'b0;
            err       <= 1'b0;
        end else begin
            shadow    <= shadow_nxt;
            shadow_dp <= shadow_dp_nxt;
            seen      <= frame_done ? 4'b0000 : seen_nxt;
            valid     <= frame_done;
            err       <= bad_sample;
            if (frame_done) begin
                data    <= shadow_nxt;
                dp_mask <= shadow_dp_nxt;
            end
        end
    end

endmodule

// File: tb/tb_sseg4_decode.sv
// tb_sseg4_decode: directed scans of a multiplexed display into sseg4_decode,
// with hand-computed expected frames and pulse counts.
module tb_sseg4_decode;

    logic        clk;
    logic        rst;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dp;
    logic [15:0] data;
    logic [3:0]  dp_mask;
    logic        valid;
    logic        err;

    int total;
    int bad;

    int          valid_cnt;
    int          err_cnt;
    int          both_cnt;
    int          stray_change_cnt;
    logic [15:0] last_data;
    logic [3:0]  last_dp;
    logic [15:0] prev_data;

    int v0;
    int e0;

    sseg4_decode #(.SETTLE(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .seg     (seg),
        .an      (an),
        .dp      (dp),
        .data    (data),
        .dp_mask (dp_mask),
        .valid   (valid),
        .err     (err)
    );

    // 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Observe output pulses on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            if (valid) begin
                valid_cnt <= valid_cnt + 1;
                last_data <= data;
                last_dp   <= dp_mask;
            end
            if (err)
                err_cnt <= err_cnt + 1;
            if (valid && err)
                both_cnt <= both_cnt + 1;
            if (data != prev_data && !valid)
                stray_change_cnt <= stray_change_cnt + 1;
        end
        prev_data <= data;
    end

    // Active-high gfedcba pattern for each hex digit
    function automatic logic [6:0] hex_seg(input logic [3:0] h);
        case (h)
            4'h0: hex_seg = 7'h3F;
            4'h1: hex_seg = 7'h06;
            4'h2: hex_seg = 7'h5B;
            4'h3: hex_seg = 7'h4F;
            4'h4: hex_seg = 7'h66;
            4'h5: hex_seg = 7'h6D;
            4'h6: hex_seg = 7'h7D;
            4'h7: hex_seg = 7'h07;
            4'h8: hex_seg = 7'h7F;
            4'h9: hex_seg = 7'h6F;
            4'hA: hex_seg = 7'h77;
            4'hB: hex_seg = 7'h7C;
            4'hC: hex_seg = 7'h39;
            4'hD: hex_seg = 7'h5E;
            4'hE: hex_seg = 7'h79;
            default: hex_seg = 7'h71;
        endcase
    endfunction

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Drive raw bus values for a number of cycles
    task automatic drive_raw(input logic [3:0] an_v, input logic [6:0] seg_v, input logic dp_v, input int cycles);
        an  = an_v;
        seg = seg_v;
        dp  = dp_v;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    // Show hex value h on digit k, decimal point lit if dp_lit
    task automatic apply_stimulus(input int k, input logic [3:0] h, input logic dp_lit, input int cycles);
        logic [3:0] one;
        one = 4'b0001 << k;
        drive_raw(~one, ~hex_seg(h), ~dp_lit, cycles);
    endtask

    task automatic idle(input int cycles);
        drive_raw(4'b1111, 7'h7F, 1'b1, cycles);
    endtask

    task automatic scan_frame(input logic [15:0] val, input logic [3:0] dpm);
        for (int k = 0; k < 4; k++)
            apply_stimulus(k, val[4*k +: 4], dpm[k], 8);
    endtask

    task automatic snap;
        v0 = valid_cnt;
        e0 = err_cnt;
    endtask

    initial begin
        total            = 0;
        bad              = 0;
        valid_cnt        = 0;
        err_cnt          = 0;
        both_cnt         = 0;
        stray_change_cnt = 0;
        last_data        = 16'h0;
        last_dp          = 4'h0;
        prev_data        = 16'h0;
        rst = 1'b1;
        an  = 4'b1111;
        seg = 7'h7F;
        dp  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_data", 32'(data), 32'h0000);
        check_output("reset_dp_mask", 32'(dp_mask), 32'h0);
        check_output("reset_valid", 32'(valid), 32'h0);
        check_output("reset_err", 32'(err), 32'h0);
        rst = 1'b0;
        idle(2);

        // Anodes toggling faster than the settle window
        snap();
        for (int i = 0; i < 20; i++)
            apply_stimulus(i % 2, 4'h8, 1'b0, 2);
        idle(6);
        check_output("fast_toggle_valid", 32'(valid_cnt - v0), 32'd0);
        check_output("fast_toggle_err", 32'(err_cnt - e0), 32'd0);
        check_output("fast_toggle_data", 32'(data), 32'h0000);

        // Two full scans of 0,0,A,B
        snap();
        scan_frame(16'h00AB, 4'b0000);
        scan_frame(16'h00AB, 4'b0000);
        idle(4);
        check_output("scan_valid_count", 32'(valid_cnt - v0), 32'd2);
        check_output("scan_err_count", 32'(err_cnt - e0), 32'd0);
        check_output("scan_data", 32'(last_data), 32'h00AB);
        check_output("scan_dp_mask", 32'(last_dp), 32'h0);

        // Decimal point on digit 1
        snap();
        scan_frame(16'h00AB, 4'b0010);
        idle(4);
        check_output("dp_valid_count", 32'(valid_cnt - v0), 32'd1);
        check_output("dp_data", 32'(data), 32'h00AB);
        check_output("dp_mask", 32'(dp_mask), 32'b0010);

        // Blank segment pattern on digit 2 blocks the frame until it decodes
        snap();
        apply_stimulus(0, 4'h1, 1'b0, 8);
        apply_stimulus(1, 4'h2, 1'b0, 8);
        drive_raw(4'b1011, 7'b1111111, 1'b1, 8);
        apply_stimulus(3, 4'h4, 1'b0, 8);
        check_output("badseg_err", 32'(err_cnt - e0), 32'd1);
        check_output("badseg_no_valid", 32'(valid_cnt - v0), 32'd0);
        apply_stimulus(2, 4'h3, 1'b0, 8);
        idle(4);
        check_output("badseg_recover_valid", 32'(valid_cnt - v0), 32'd1);
        check_output("badseg_recover_data", 32'(data), 32'h4321);

        // Two anodes low: single error and partial frame survives
        snap();
        apply_stimulus(0, 4'h9, 1'b0, 8);
        apply_stimulus(1, 4'h8, 1'b0, 8);
        drive_raw(4'b1100, ~hex_seg(4'h5), 1'b1, 6);
        check_output("multi_low_err", 32'(err_cnt - e0), 32'd1);
        apply_stimulus(2, 4'hE, 1'b0, 8);
        apply_stimulus(3, 4'hF, 1'b1, 8);
        idle(4);
        check_output("multi_low_valid", 32'(valid_cnt - v0), 32'd1);
        check_output("multi_low_data", 32'(data), 32'hFE89);
        check_output("multi_low_dp", 32'(dp_mask), 32'b1000);
        check_output("multi_low_err_total", 32'(err_cnt - e0), 32'd1);

        // Reset mid-frame discards digits already captured
        apply_stimulus(0, 4'h4, 1'b0, 8);
        apply_stimulus(1, 4'h3, 1'b0, 8);
        apply_stimulus(2, 4'h2, 1'b0, 8);
        rst = 1'b1;
        #1;
        check_output("midreset_data", 32'(data), 32'h0000);
        check_output("midreset_dp", 32'(dp_mask), 32'h0);
        idle(2);
        rst = 1'b0;
        idle(2);
        snap();
        apply_stimulus(3, 4'h5, 1'b0, 8);
        check_output("midreset_no_early_valid", 32'(valid_cnt - v0), 32'd0);
        apply_stimulus(0, 4'h8, 1'b0, 8);
        apply_stimulus(1, 4'h7, 1'b0, 8);
        apply_stimulus(2, 4'h6, 1'b0, 8);
        idle(4);
        check_output("midreset_valid", 32'(valid_cnt - v0), 32'd1);
        check_output("midreset_data_after", 32'(last_data), 32'h5678);

        check_output("valid_err_overlap", 32'(both_cnt), 32'd0);
        check_output("data_change_without_valid", 32'(stray_change_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
